// File: rtl/karatsuba_pkg.sv
// Shared width helpers for the Karatsuba multiplier datapath.
package karatsuba_pkg;

  function automatic int kar_lo_w(input int n);
    return (n + 1) / 2;
  endfunction

  function automatic int kar_hi_w(input int n);
    return n / 2;
  endfunction

  // The cross product (a0+a1)*(b0+b1) needs one carry bit per factor.
  function automatic int kar_x_w(input int n);
    return 2 * kar_lo_w(n) + 2;
  endfunction

endpackage

// File: rtl/karatsuba_pipe_stage.sv
// Valid/ready register slice: one entry of data plus its valid flag.
module karatsuba_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             d_vld,
  input  logic [WIDTH-1:0] d,
  output logic             vld,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (adv) begin
      vld <= d_vld;
      // Data only moves when a real entry arrives, so idle bubbles keep the old value.
      if (d_vld) q <= d;
    end
  end

endmodule

// File: rtl/karatsuba_recombine.sv
// Two-stage recombination of Karatsuba partial products into the full product.
// Optional sticky borrow check enabled by defining KARATSUBA_RECOMBINE_CHECK_EN.
module karatsuba_recombine
  import karatsuba_pkg::*;
#(
  parameter int N_BITS = 15
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [2*kar_lo_w(N_BITS)-1:0]        p_lo,
  input  logic [2*kar_hi_w(N_BITS)-1:0]        p_hi,
  input  logic [kar_x_w(N_BITS)-1:0]           p_x,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [2*N_BITS-1:0]                  out_c
`ifdef KARATSUBA_RECOMBINE_CHECK_EN
  ,
  output logic                                 err
`endif
);

  localparam int H   = kar_lo_w(N_BITS);
  localparam int L   = kar_hi_w(N_BITS);
  localparam int XW  = kar_x_w(N_BITS);
  localparam int CW  = 2 * N_BITS;
  localparam int S1W = XW + 2 * L + 2 * H;

  function automatic logic [XW-1:0] middle(input logic [XW-1:0]    x,
                                           input logic [2*H-1:0]   lo,
                                           input logic [2*L-1:0]   hi);
    return x - XW'(lo) - XW'(hi);
  endfunction

  function automatic logic [CW-1:0] recombine(input logic [XW-1:0]  mid,
                                              input logic [2*H-1:0] lo,
                                              input logic [2*L-1:0] hi);
    return (CW'(hi) << (2 * H)) + (CW'(mid) << H) + CW'(lo);
  endfunction

  logic           s1_v, s2_v;
  logic           s1_adv, s2_adv;
  logic [XW-1:0]  mid_p0;
  logic [S1W-1:0] d_p1, q_p1;
  logic [XW-1:0]  mid_p1;
  logic [2*H-1:0] lo_p1;
  logic [2*L-1:0] hi_p1;
  logic [CW-1:0]  c_p1;

  assign s2_adv   = !s2_v || out_ready;
  assign s1_adv   = !s1_v || s2_adv;
  assign in_ready = s1_adv;

  // Stage 0 -> 1: middle term, carried with the raw low/high products
  assign mid_p0 = middle(p_x, p_lo, p_hi);
  assign d_p1   = {mid_p0, p_hi, p_lo};

  karatsuba_pipe_stage #(.WIDTH(S1W)) u_s1 (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (s1_adv),
    .d_vld (in_valid),
    .d     (d_p1),
    .vld   (s1_v),
    .q     (q_p1)
  );

  // Stage 1 -> 2: shifted sum into the full-width product
  assign {mid_p1, hi_p1, lo_p1} = q_p1;
  assign c_p1 = recombine(mid_p1, lo_p1, hi_p1);

  karatsuba_pipe_stage #(.WIDTH(CW)) u_s2 (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (s2_adv),
    .d_vld (s1_v),
    .d     (c_p1),
    .vld   (s2_v),
    .q     (out_c)
  );

  assign out_valid = s2_v;

`ifdef KARATSUBA_RECOMBINE_CHECK_EN
  logic borrow_p0;

  // A borrow means the partial products cannot come from one real multiplication.
  assign borrow_p0 = {1'b0, p_x} < ((XW + 1)'(p_lo) + (XW + 1)'(p_hi));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                err <= 1'b0;
    else if (in_valid && in_ready && borrow_p0) err <= 1'b1;
  end
`endif

endmodule
